// File: rtl/krnl_cam_pkg.sv
// Shared constants, types and helpers for the CAM search controller.
package krnl_cam_pkg;

    localparam int unsigned C_DATA_WIDTH  = 512;
    localparam int unsigned OP_CODE_WIDTH = 3;
    localparam int unsigned KEY_WIDTH     = 32;
    localparam int unsigned CAM_LATENCY   = 2;
    localparam int unsigned FIFO_DEPTH    = 4;

    localparam int unsigned KEYS_PER_WORD = C_DATA_WIDTH / KEY_WIDTH;
    localparam int unsigned KEY_SHIFT     = $clog2(KEYS_PER_WORD);
    localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W         = CNT_W + 1;

    // Result slot layout: top bit flags a hit, the rest carries the entry address.
    localparam int unsigned HIT_BIT    = KEY_WIDTH - 1;
    localparam int unsigned ADDR_LSB   = 0;
    localparam int unsigned ADDR_WIDTH = KEY_WIDTH - 1;

    localparam logic [OP_CODE_WIDTH-1:0] IDLE       = 3'd0;
    localparam logic [OP_CODE_WIDTH-1:0] UPDATE_ALL = 3'd1;
    localparam logic [OP_CODE_WIDTH-1:0] SEARCH     = 3'd2;
    localparam logic [OP_CODE_WIDTH-1:0] UPDATE_ONE = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } search_state_e;

    typedef struct packed {
        logic                     vld;
        logic                     last;
        logic [KEYS_PER_WORD-1:0] mask;
    } pipe_ent_t;

    function automatic logic [KEYS_PER_WORD-1:0] slot_mask(input logic [31:0] n);
        logic [KEYS_PER_WORD-1:0] m;
        for (int i = 0; i < KEYS_PER_WORD; i++) begin
            m[i] = (n > 32'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/krnl_cam_search_ctrl_if.sv
// Key stream, CAM issue/return and result stream of the search controller.
interface krnl_cam_search_ctrl_if;
    import krnl_cam_pkg::*;

    logic [C_DATA_WIDTH-1:0] key_tdata;
    logic                    key_tvalid;
    logic                    key_tready;
    logic [C_DATA_WIDTH-1:0] cam_key;
    logic                    cam_key_valid;
    logic [C_DATA_WIDTH-1:0] cam_match;
    logic                    cam_match_valid;
    logic [C_DATA_WIDTH-1:0] res_tdata;
    logic                    res_tvalid;
    logic                    res_tready;
    logic                    res_tlast;

    modport slave (
        input  key_tdata, key_tvalid, cam_match, cam_match_valid, res_tready,
        output key_tready, cam_key, cam_key_valid, res_tdata, res_tvalid, res_tlast
    );

    modport master (
        output key_tdata, key_tvalid, cam_match, cam_match_valid, res_tready,
        input  key_tready, cam_key, cam_key_valid, res_tdata, res_tvalid, res_tlast
    );

endinterface

// File: rtl/krnl_cam_result_fifo.sv
// Synchronous result FIFO with flush; push and pop together keep occupancy, even when full.
module krnl_cam_result_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 513
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, do_write, do_read;

    assign full     = (count_q == CntW'(Depth));
    assign empty_o  = (count_q == '0);
    assign do_read  = pop_i && !empty_o && !flush_i;
    assign do_write = push_i && (!full || do_read) && !flush_i;
    assign data_o   = mem_q[rptr_q];
    assign count_o  = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_write) begin
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (do_read) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/krnl_cam_search_ctrl.sv
// CAM search controller: streams keys into the CAM and packs match words for write-back.
// Optional hit statistic enabled by defining CAM_SEARCH_STATS_EN.
module krnl_cam_search_ctrl
    import krnl_cam_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OP_CODE_WIDTH-1:0] state,
    input  logic [31:0]              compare_num,
    krnl_cam_search_ctrl_if.slave    bus,
    output logic                     state_end,
    output logic [31:0]              hit_count
);

    search_state_e st_q, st_d;
    logic          search_q, search_prev_q, rise, abort;
    logic [31:0]   keys_left_q, keys_left_d, words_total_q, words_total_d;
    logic [31:0]   words_issued_q, words_issued_d, take;
    logic [32:0]   words_sum, words_div;
    logic [OUT_W-1:0] inflight_q, inflight_d, outstanding;
    logic [CNT_W-1:0] fifo_cnt;
    logic          fifo_empty, key_tready, issue, issue_last, ret, push, pop;
    pipe_ent_t [CAM_LATENCY-1:0] pipe_q, pipe_d;
    pipe_ent_t     head;
    logic [C_DATA_WIDTH-1:0] push_data;
    logic [C_DATA_WIDTH:0]   fifo_head;

    // The FSM state input is registered, so a new search is seen one cycle after entry.
    assign rise  = search_q && !search_prev_q;
    assign abort = ((st_q == S_ISSUE) || (st_q == S_DRAIN)) && !search_q;

    assign outstanding = inflight_q + OUT_W'(fifo_cnt);
    assign key_tready  = (st_q == S_ISSUE) && !abort && (outstanding < OUT_W'(FIFO_DEPTH));
    assign issue       = key_tready && bus.key_tvalid;
    assign issue_last  = (words_issued_q + 32'd1 == words_total_q);
    assign take        = (keys_left_q >= 32'(KEYS_PER_WORD)) ? 32'(KEYS_PER_WORD) : keys_left_q;
    assign words_sum   = {1'b0, compare_num} + 33'(KEYS_PER_WORD - 1);
    assign words_div   = words_sum >> KEY_SHIFT;

    assign bus.key_tready    = key_tready;
    assign bus.cam_key       = issue ? bus.key_tdata : '0;
    assign bus.cam_key_valid = issue;

    assign head = pipe_q[CAM_LATENCY-1];
    assign ret  = bus.cam_match_valid && (inflight_q != '0);
    assign push = bus.cam_match_valid && head.vld && !abort;
    assign pop  = bus.res_tvalid && bus.res_tready;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < KEYS_PER_WORD; i++) begin
            if (head.mask[i]) begin
                push_data[i*KEY_WIDTH +: KEY_WIDTH] = bus.cam_match[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
    end

    krnl_cam_result_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (C_DATA_WIDTH + 1)
    ) u_result_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (abort),
        .push_i  (push),
        .data_i  ({head.last, push_data}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    assign bus.res_tvalid = !fifo_empty;
    assign bus.res_tdata  = fifo_empty ? '0 : fifo_head[C_DATA_WIDTH-1:0];
    assign bus.res_tlast  = !fifo_empty && fifo_head[C_DATA_WIDTH];

    always_comb begin
        st_d           = st_q;
        keys_left_d    = keys_left_q;
        words_total_d  = words_total_q;
        words_issued_d = words_issued_q;
        state_end      = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (rise) begin
                    keys_left_d    = compare_num;
                    words_total_d  = words_div[31:0];
                    words_issued_d = '0;
                    st_d           = (compare_num == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    st_d = S_IDLE;
                end else if (issue) begin
                    words_issued_d = words_issued_q + 32'd1;
                    keys_left_d    = keys_left_q - take;
                    if (issue_last) begin
                        st_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    st_d = S_IDLE;
                end else if (pop && bus.res_tlast) begin
                    st_d = S_DONE;
                end
            end
            S_DONE: begin
                state_end = 1'b1;
                st_d      = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Mask pipe lines each issued word up with its CAM return; an empty entry discards it.
    always_comb begin
        pipe_d = '0;
        if (!abort) begin
            pipe_d[0].vld  = issue;
            pipe_d[0].last = issue && issue_last;
            pipe_d[0].mask = issue ? slot_mask(keys_left_q) : '0;
            for (int i = 1; i < CAM_LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !ret) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && ret) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q           <= S_IDLE;
            search_q       <= 1'b0;
            search_prev_q  <= 1'b0;
            keys_left_q    <= '0;
            words_total_q  <= '0;
            words_issued_q <= '0;
            inflight_q     <= '0;
            pipe_q         <= '0;
        end else begin
            st_q           <= st_d;
            search_q       <= (state == SEARCH);
            search_prev_q  <= search_q;
            keys_left_q    <= keys_left_d;
            words_total_q  <= words_total_d;
            words_issued_q <= words_issued_d;
            inflight_q     <= inflight_d;
            pipe_q         <= pipe_d;
        end
    end

`ifdef CAM_SEARCH_STATS_EN
    logic [31:0] hit_q, hit_d, word_hits;
    logic [32:0] hit_sum;

    always_comb begin
        word_hits = '0;
        for (int i = 0; i < KEYS_PER_WORD; i++) begin
            word_hits = word_hits + 32'(push_data[i*KEY_WIDTH + HIT_BIT]);
        end
        hit_sum = {1'b0, hit_q} + {1'b0, word_hits};
        hit_d   = hit_q;
        if ((st_q == S_IDLE) && rise) begin
            hit_d = '0;
        end else if (push) begin
            hit_d = hit_sum[32] ? 32'hFFFF_FFFF : hit_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_count = hit_q;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_krnl_cam_search_ctrl.sv
// Directed self-checking bench for krnl_cam_search_ctrl with a fixed-latency CAM model.
module tb_krnl_cam_search_ctrl;
    import krnl_cam_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [OP_CODE_WIDTH-1:0] state;
    logic [31:0]              compare_num;
    logic                     state_end;
    logic [31:0]              hit_count;

    krnl_cam_search_ctrl_if bus ();

    krnl_cam_search_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .compare_num (compare_num),
        .bus         (bus),
        .state_end   (state_end),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

    // CAM model: echoes the issued key word back exactly CAM_LATENCY cycles later.
    logic                    p1_v = 1'b0, p2_v = 1'b0;
    logic [C_DATA_WIDTH-1:0] p1_d = '0, p2_d = '0;
    always @(posedge clk) begin
        p1_v <= bus.cam_key_valid;
        p1_d <= bus.cam_key;
        p2_v <= p1_v;
        p2_d <= p1_d;
    end
    assign bus.cam_match       = p2_d;
    assign bus.cam_match_valid = p2_v;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc_cnt, res_cnt, rdy_cnt, vld_cnt, end_cnt, end_cyc, unstable, ovf;
    int acc_cyc [32];
    int res_cyc [32];
    logic [C_DATA_WIDTH-1:0] res_data [32];
    logic                    res_last [32];
    logic                    stall_q = 1'b0;
    logic [C_DATA_WIDTH-1:0] stall_data = '0;

    always @(negedge clk) begin
        if (bus.key_tvalid && bus.key_tready) begin
            if (acc_cnt < 32) acc_cyc[acc_cnt] = cyc;
            acc_cnt++;
        end
        if (bus.key_tready) rdy_cnt++;
        if (bus.res_tvalid) vld_cnt++;
        if (bus.res_tvalid && bus.res_tready) begin
            if (res_cnt < 32) begin
                res_data[res_cnt] = bus.res_tdata;
                res_last[res_cnt] = bus.res_tlast;
                res_cyc[res_cnt]  = cyc;
            end
            res_cnt++;
        end
        if (stall_q && bus.res_tdata !== stall_data) unstable++;
        stall_q    = bus.res_tvalid && !bus.res_tready;
        stall_data = bus.res_tdata;
        if (state_end) begin
            end_cyc = cyc;
            end_cnt++;
        end
        if (dut.push && !dut.pop && dut.fifo_cnt == CNT_W'(FIFO_DEPTH)) ovf++;
    end

    task automatic chk(input string tag, input logic [C_DATA_WIDTH-1:0] obs,
                       input logic [C_DATA_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        acc_cnt = 0; res_cnt = 0; rdy_cnt = 0; vld_cnt = 0; end_cnt = 0; end_cyc = -1;
    endtask

    function automatic logic [C_DATA_WIDTH-1:0] pat(input logic [31:0] base, input int k);
        logic [C_DATA_WIDTH-1:0] w;
        for (int i = 0; i < KEYS_PER_WORD; i++) w[i*KEY_WIDTH +: KEY_WIDTH] = base + 32'(16*k + i);
        return w;
    endfunction

    function automatic logic [C_DATA_WIDTH-1:0] keep(input logic [C_DATA_WIDTH-1:0] w, input int n);
        logic [C_DATA_WIDTH-1:0] r;
        r = w;
        for (int i = n; i < KEYS_PER_WORD; i++) r[i*KEY_WIDTH +: KEY_WIDTH] = '0;
        return r;
    endfunction

    task automatic send_word(input string tag, input logic [C_DATA_WIDTH-1:0] d);
        int t;
        bus.key_tdata  = d;
        bus.key_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.key_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, C_DATA_WIDTH'(bus.key_tready), 1);
        @(posedge clk);
        #1;
        bus.key_tvalid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int t;
        t = 0;
        while (end_cnt == 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(tag, C_DATA_WIDTH'(end_cnt), 1);
        state = IDLE;
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [C_DATA_WIDTH-1:0] wa, wb, tmp;
    int s0, lasts, exp_hits;

    initial begin
        rst_n = 1'b0; state = IDLE; compare_num = '0;
        bus.key_tvalid = 1'b0; bus.key_tdata = '0; bus.res_tready = 1'b1;
        unstable = 0; ovf = 0;
        clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_tready", C_DATA_WIDTH'(bus.key_tready), 0);
        chk("rst_res_tvalid", C_DATA_WIDTH'(bus.res_tvalid), 0);
        chk("rst_res_tdata", bus.res_tdata, '0);
        chk("rst_cam_key_valid", C_DATA_WIDTH'(bus.cam_key_valid), 0);
        chk("rst_state_end", C_DATA_WIDTH'(state_end), 0);
        chk("rst_hit_count", C_DATA_WIDTH'(hit_count), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 40 keys -> 3 words, last word holds 8 valid slots
        clear();
        compare_num = 32'd40; state = SEARCH;
        for (int k = 0; k < 3; k++) send_word("t1_accept", pat(32'h100, k));
        wait_end("t1_end_once", 100);
        chk("t1_res_cnt", C_DATA_WIDTH'(res_cnt), 3);
        chk("t1_word0", res_data[0], pat(32'h100, 0));
        chk("t1_word1", res_data[1], pat(32'h100, 1));
        chk("t1_word2", res_data[2], keep(pat(32'h100, 2), 8));
        tmp = res_data[2];
        chk("t1_w2_slot7", C_DATA_WIDTH'(tmp[7*32 +: 32]), 32'h0000_0127);
        chk("t1_w2_slot8", C_DATA_WIDTH'(tmp[8*32 +: 32]), 0);
        chk("t1_w2_slot15", C_DATA_WIDTH'(tmp[15*32 +: 32]), 0);
        chk("t1_lasts", C_DATA_WIDTH'({res_last[0], res_last[1], res_last[2]}), 3'b001);
        for (int k = 0; k < 3; k++) chk("t1_latency", C_DATA_WIDTH'(res_cyc[k] - acc_cyc[k]), 3);
        chk("t1_end_after_pop", C_DATA_WIDTH'(end_cyc - res_cyc[2]), 1);

        // zero keys: straight to completion
        clear();
        compare_num = 32'd0; state = SEARCH; s0 = cyc;
        wait_end("t2_end_once", 20);
        chk("t2_end_latency", C_DATA_WIDTH'(end_cyc - s0), 2);
        chk("t2_no_ready", C_DATA_WIDTH'(rdy_cnt), 0);
        chk("t2_no_result", C_DATA_WIDTH'(vld_cnt), 0);

        // backpressure: 10 words with the result stream stalled for 20 cycles
        clear();
        compare_num = 32'd160; bus.res_tready = 1'b0; state = SEARCH;
        fork
            begin
                for (int k = 0; k < 10; k++) send_word("t3_accept", pat(32'h300, k));
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("t3_credit_stop", C_DATA_WIDTH'(acc_cnt), 4);
                chk("t3_stall_valid", C_DATA_WIDTH'(bus.res_tvalid), 1);
                chk("t3_stall_head", bus.res_tdata, pat(32'h300, 0));
                bus.res_tready = 1'b1;
            end
        join
        wait_end("t3_end_once", 200);
        chk("t3_res_cnt", C_DATA_WIDTH'(res_cnt), 10);
        lasts = 0;
        for (int k = 0; k < 10; k++) begin
            chk("t3_order", res_data[k], pat(32'h300, k));
            if (res_last[k]) lasts++;
        end
        chk("t3_one_last", C_DATA_WIDTH'(lasts), 1);
        chk("t3_last_on_10", C_DATA_WIDTH'(res_last[9]), 1);
        chk("t3_stable", C_DATA_WIDTH'(unstable), 0);

        // abort after 5 of 10 words, then a fresh one-word search
        clear();
        compare_num = 32'd160; state = SEARCH;
        for (int k = 0; k < 5; k++) send_word("t4_accept", pat(32'h400, k));
        state = IDLE; bus.res_tready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t4_flushed", C_DATA_WIDTH'(bus.res_tvalid), 0);
        chk("t4_no_ready", C_DATA_WIDTH'(bus.key_tready), 0);
        chk("t4_no_end", C_DATA_WIDTH'(end_cnt), 0);
        bus.res_tready = 1'b1;
        clear();
        repeat (4) @(posedge clk);
        #1;
        chk("t4_no_stale", C_DATA_WIDTH'(vld_cnt), 0);
        compare_num = 32'd16; state = SEARCH;
        send_word("t4b_accept", pat(32'h500, 0));
        wait_end("t4b_end_once", 50);
        chk("t4b_res_cnt", C_DATA_WIDTH'(res_cnt), 1);
        chk("t4b_word", res_data[0], pat(32'h500, 0));
        chk("t4b_last", C_DATA_WIDTH'(res_last[0]), 1);

        // reset with two results in flight
        clear();
        compare_num = 32'd160; state = SEARCH;
        send_word("t5_accept", pat(32'h700, 0));
        send_word("t5_accept", pat(32'h700, 1));
        rst_n = 1'b0; state = IDLE;
        @(posedge clk);
        #1;
        chk("t5_key_tready", C_DATA_WIDTH'(bus.key_tready), 0);
        chk("t5_cam_key_valid", C_DATA_WIDTH'(bus.cam_key_valid), 0);
        chk("t5_cam_key", bus.cam_key, '0);
        chk("t5_res_tvalid", C_DATA_WIDTH'(bus.res_tvalid), 0);
        chk("t5_res_tdata", bus.res_tdata, '0);
        chk("t5_res_tlast", C_DATA_WIDTH'(bus.res_tlast), 0);
        chk("t5_state_end", C_DATA_WIDTH'(state_end), 0);
        chk("t5_hit_count", C_DATA_WIDTH'(hit_count), 0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_late_discarded", C_DATA_WIDTH'(vld_cnt), 0);
        chk("t5_no_end", C_DATA_WIDTH'(end_cnt), 0);

        // hit statistic: 7 hits in valid slots, one hit in masked slot 5 of word 2
        clear();
        wa = pat(32'h600, 0);
        wb = pat(32'h600, 1);
        wa[0*32 + 31] = 1'b1; wa[3*32 + 31] = 1'b1; wa[7*32 + 31] = 1'b1; wa[15*32 + 31] = 1'b1;
        wb[0*32 + 31] = 1'b1; wb[2*32 + 31] = 1'b1; wb[3*32 + 31] = 1'b1; wb[5*32 + 31] = 1'b1;
        compare_num = 32'd20; state = SEARCH;
        send_word("t6_accept", wa);
        send_word("t6_accept", wb);
        wait_end("t6_end_once", 50);
        chk("t6_res_cnt", C_DATA_WIDTH'(res_cnt), 2);
        tmp = res_data[1];
        chk("t6_w2_slot2", C_DATA_WIDTH'(tmp[2*32 +: 32]), 32'h8000_0612);
        chk("t6_w2_slot4", C_DATA_WIDTH'(tmp[4*32 +: 32]), 0);
        chk("t6_w2_slot5", C_DATA_WIDTH'(tmp[5*32 +: 32]), 0);
`ifdef CAM_SEARCH_STATS_EN
        exp_hits = 7;
`else
        exp_hits = 0;
`endif
        chk("t6_hit_count", C_DATA_WIDTH'(hit_count), C_DATA_WIDTH'(exp_hits));

        chk("no_overflow", C_DATA_WIDTH'(ovf), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
